// File: rtl/perm_cmp_arbiter.sv
// Round-robin arbiter sharing one carry-free sum-equality comparator among NREQ requesters.
// Define PERM_CMP_ARB_LOCK_EN to hold the grant for one requester across a multi-beat burst.

module perm_cmp_eq #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] k,
  output logic         eq
);
  // If a+b==k, the carry into bit i+1 is maj(a,b,a^b^k); check every bit without a carry chain.
  logic [N-1:0] cy;
  assign cy = (a & b) | ((a ^ b) & ~k);
  assign eq = &(~((a ^ b ^ k) ^ {cy[N-2:0], 1'b0}));
endmodule

module perm_cmp_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*N-1:0] req_k,
  input  logic [NREQ-1:0]   req_last,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_match,
  output logic              rsp_last
);

  logic [IDW-1:0]  rr;
  logic [NREQ-1:0] elig;
  logic [IDW-1:0]  gidx;
  logic            gfound;
  logic            slot_free;
  logic            accept;
  logic            grant_end;
  logic            eq;

  assign slot_free = ~rsp_valid | rsp_ready;

  always_comb begin
    gidx   = '0;
    gfound = 1'b0;
    for (int o = 0; o < NREQ; o++) begin
      int idx;
      idx = (int'(rr) + o) % NREQ;
      if (!gfound && elig[idx]) begin
        gfound = 1'b1;
        gidx   = IDW'(idx);
      end
    end
  end

  assign accept    = gfound & slot_free & ~rst;
  assign req_ready = accept ? (NREQ'(1) << gidx) : '0;

  perm_cmp_eq #(.N(N)) u_cmp (
    .a  (req_a[gidx*N +: N]),
    .b  (req_b[gidx*N +: N]),
    .k  (req_k[gidx*N +: N]),
    .eq (eq)
  );

`ifdef PERM_CMP_ARB_LOCK_EN
  typedef enum logic {S_IDLE, S_LOCKED} lock_t;
  lock_t          state, state_nx;
  logic [IDW-1:0] owner, owner_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      owner <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
    end
  end

  // While locked, nobody but the owner is eligible, even if the owner is idle.
  always_comb begin
    elig = req_valid;
    if (state == S_LOCKED) elig = req_valid & (NREQ'(1) << owner);
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    if (accept) begin
      if (state == S_IDLE && !req_last[gidx]) begin
        state_nx = S_LOCKED;
        owner_nx = gidx;
      end else if (state == S_LOCKED && req_last[gidx]) begin
        state_nx = S_IDLE;
      end
    end
  end

  assign grant_end = req_last[gidx];
`else
  assign elig      = req_valid;
  assign grant_end = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= '0;
    end else if (accept && grant_end) begin
      rr <= (int'(gidx) == NREQ-1) ? '0 : gidx + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_match <= 1'b0;
      rsp_last  <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gidx;
      rsp_match <= eq;
      rsp_last  <= req_last[gidx];
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_perm_cmp_arbiter.sv
// Directed bench for perm_cmp_arbiter: table-driven compare vectors plus arbitration/lock/reset sequences.
module tb_perm_cmp_arbiter;
  localparam int N = 32;
  localparam int NREQ = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a, req_b, req_k;
  logic [NREQ-1:0]   req_last;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_match;
  logic              rsp_last;

  int checks = 0;
  int errors = 0;

  perm_cmp_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_k(req_k), .req_last(req_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_match(rsp_match), .rsp_last(rsp_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  id;
    logic [31:0] a, b, k;
    logic        last;
    logic        m;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Every requester gets operands whose sum matches its target.
  task automatic set_defaults();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = 32'(i * 3);
      req_b[i*N +: N] = 32'd7;
      req_k[i*N +: N] = 32'(i * 3 + 7);
    end
  endtask

  // Entered just after a rising edge: drive, check req_ready, clock, check response.
  task automatic step(input string name, input logic [3:0] v, input logic [3:0] l, input logic rr_in,
                      input logic [3:0] exp_ready, input logic exp_rv, input logic [1:0] exp_id,
                      input logic exp_m, input logic exp_l);
    req_valid = v;
    req_last  = l;
    rsp_ready = rr_in;
    #1;
    chk({name, ".ready"}, 64'(req_ready), 64'(exp_ready));
    @(posedge clk); #1;
    chk({name, ".rsp_valid"}, 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv) begin
      chk({name, ".rsp_id"}, 64'(rsp_id), 64'(exp_id));
      chk({name, ".rsp_match"}, 64'(rsp_match), 64'(exp_m));
      chk({name, ".rsp_last"}, 64'(rsp_last), 64'(exp_l));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    req_last = 4'hF;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset.ready", 64'(req_ready), 64'h0);
    chk("reset.rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset.rsp_id", 64'(rsp_id), 64'h0);
    chk("reset.rsp_match", 64'(rsp_match), 64'h0);
    chk("reset.rsp_last", 64'(rsp_last), 64'h0);
    rst = 1'b0;
    req_valid = '0;
    req_last = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_k = '0;
    set_defaults();

    tv[0] = '{2'd0, 32'd5,        32'd7,        32'd12,       1'b1, 1'b1};
    tv[1] = '{2'd0, 32'd5,        32'd7,        32'd13,       1'b1, 1'b0};
    tv[2] = '{2'd0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b1};
    tv[3] = '{2'd0, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b1, 1'b0};
    tv[4] = '{2'd1, 32'h80000000, 32'h80000000, 32'd0,        1'b1, 1'b1};
    tv[5] = '{2'd3, 32'h12345678, 32'h0FEDCBA8, 32'h22222220, 1'b1, 1'b1};
    tv[6] = '{2'd2, 32'h12345678, 32'h0FEDCBA8, 32'h22222221, 1'b1, 1'b0};
    tv[7] = '{2'd2, 32'd0,        32'd0,        32'd0,        1'b1, 1'b1};
    tv[8] = '{2'd1, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b1, 1'b1};
    tv[9] = '{2'd1, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFE, 1'b1, 1'b0};

    do_reset();

    // Single-requester compare vectors; rr is irrelevant with one requester valid.
    for (int t = 0; t < 10; t++) begin
      req_a[tv[t].id*N +: N] = tv[t].a;
      req_b[tv[t].id*N +: N] = tv[t].b;
      req_k[tv[t].id*N +: N] = tv[t].k;
      step($sformatf("vec%0d", t), 4'(1) << tv[t].id, 4'(tv[t].last) << tv[t].id, 1'b1,
           4'(1) << tv[t].id, 1'b1, tv[t].id, tv[t].m, tv[t].last);
    end
    set_defaults();

    // Fairness with all requesters valid, single-beat grants.
    do_reset();
    for (int c = 0; c < 6; c++)
      step($sformatf("fair%0d", c), 4'hF, 4'hF, 1'b1, 4'(1) << (c % 4), 1'b1, 2'(c % 4), 1'b1, 1'b1);

    // Back-pressure: response held, no grants, then pop and accept in the same cycle.
    do_reset();
    req_k[1*N +: N] = 32'd0;
    step("bp.first", 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++)
      step($sformatf("bp.hold%0d", c), 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b1);
    step("bp.release", 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0);
    step("bp.drain", 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    set_defaults();

    // Burst from requester 2 competing with requester 1.
    do_reset();
    step("burst.a", 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);
`ifdef PERM_CMP_ARB_LOCK_EN
    step("burst.b", 4'b0110, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);
    step("burst.gap0", 4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    step("burst.gap1", 4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    step("burst.c", 4'b0110, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1);
    step("burst.d", 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0);
`else
    // Without locking every beat ends the grant, so rr=3 and requester 1 wins next.
    step("burst.b", 4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0);
    step("burst.gap0", 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0);
    step("burst.gap1", 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0);
    step("burst.c", 4'b0110, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b1);
    step("burst.d", 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0);
`endif

    // Reset after the first beat of a burst from requester 3.
    do_reset();
    step("rstb.first", 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0);
    rst = 1'b1;
    req_valid = 4'b1001;
    #1;
    chk("rstb.ready_in_rst", 64'(req_ready), 64'h0);
    @(posedge clk); #1;
    chk("rstb.rsp_valid", 64'(rsp_valid), 64'h0);
    rst = 1'b0;
    step("rstb.after", 4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
